// File: rtl/freelist.sv
// Circular free list of physical registers: two allocate ports and two compacting release ports.
// Optional FREELIST_COUNT_EN adds a registered free_count output.
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif

module freelist (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr0_alloc_req,
  input  logic              instr1_alloc_req,
  output logic              alloc_ready,
  output logic [`PREG_RANGE] instr0_alloc_preg,
  output logic [`PREG_RANGE] instr1_alloc_preg,
  input  logic              instr0_release_valid,
  input  logic              instr1_release_valid,
  input  logic [`PREG_RANGE] instr0_release_preg,
  input  logic [`PREG_RANGE] instr1_release_preg,
  output logic              overflow_err
`ifdef FREELIST_COUNT_EN
  ,
  output logic [5:0]        free_count
`endif
);

  logic [5:0] entry_r [32];
  logic [4:0] head_r;
  logic [4:0] tail_r;
  logic [5:0] count_r;
  logic       overflow_r;

  logic [1:0] nreq_s;
  logic [1:0] nalloc_s;
  logic [1:0] nacc_s;
  logic       ready_s;
  logic       accept0_s;
  logic       accept1_s;
  logic       drop_s;
  logic [6:0] base_s;
  logic [4:0] wr1_idx_s;
  logic [5:0] count_nxt_s;

  // Allocation decision; readiness looks only at the registered count (no release bypass).
  always_comb begin
    nreq_s  = {1'b0, instr0_alloc_req} + {1'b0, instr1_alloc_req};
    ready_s = (count_r >= {4'b0000, nreq_s});
    if ((nreq_s != 2'd0) && ready_s) begin
      nalloc_s = nreq_s;
    end else begin
      nalloc_s = 2'd0;
    end
  end

  // Allocated register per slot; slot1 takes the head entry when slot0 is idle.
  always_comb begin
    instr0_alloc_preg = 6'd0;
    instr1_alloc_preg = 6'd0;
    if (instr0_alloc_req) begin
      instr0_alloc_preg = entry_r[head_r];
    end else begin
      instr0_alloc_preg = 6'd0;
    end
    if (instr1_alloc_req && instr0_alloc_req) begin
      instr1_alloc_preg = entry_r[head_r + 5'd1];
    end else if (instr1_alloc_req) begin
      instr1_alloc_preg = entry_r[head_r];
    end else begin
      instr1_alloc_preg = 6'd0;
    end
  end

  // Release acceptance against the space left after this cycle's allocation; slot0 first.
  always_comb begin
    base_s    = {1'b0, count_r} - {5'b00000, nalloc_s};
    accept0_s = instr0_release_valid && (base_s < 7'd32);
    if (accept0_s) begin
      accept1_s = instr1_release_valid && (base_s < 7'd31);
    end else begin
      accept1_s = instr1_release_valid && (base_s < 7'd32);
    end
    drop_s      = (instr0_release_valid && !accept0_s) || (instr1_release_valid && !accept1_s);
    nacc_s      = {1'b0, accept0_s} + {1'b0, accept1_s};
    wr1_idx_s   = tail_r + {4'b0000, accept0_s};
    count_nxt_s = count_r - {4'b0000, nalloc_s} + {4'b0000, nacc_s};
  end

  // Pointer, count and sticky error state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r     <= 5'd0;
      tail_r     <= 5'd0;
      count_r    <= 6'd32;
      overflow_r <= 1'b0;
    end else begin
      head_r     <= head_r + {3'b000, nalloc_s};
      tail_r     <= tail_r + {3'b000, nacc_s};
      count_r    <= count_nxt_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Entry storage; reset leaves pregs 32..63 free in order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        entry_r[i] <= 6'd32 + 6'(i);
      end
    end else begin
      if (accept0_s) begin
        entry_r[tail_r] <= instr0_release_preg;
      end
      if (accept1_s) begin
        entry_r[wr1_idx_s] <= instr1_release_preg;
      end
    end
  end

  assign alloc_ready  = ready_s;
  assign overflow_err = overflow_r;
`ifdef FREELIST_COUNT_EN
  assign free_count   = count_r;
`endif

endmodule

// File: tb/tb_freelist.sv
// Directed self-checking bench for freelist; free_count checks compile only under FREELIST_COUNT_EN.
module tb_freelist;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr0_alloc_req = 1'b0;
  logic       instr1_alloc_req = 1'b0;
  logic       alloc_ready;
  logic [5:0] instr0_alloc_preg;
  logic [5:0] instr1_alloc_preg;
  logic       instr0_release_valid = 1'b0;
  logic       instr1_release_valid = 1'b0;
  logic [5:0] instr0_release_preg = 6'd0;
  logic [5:0] instr1_release_preg = 6'd0;
  logic       overflow_err;
`ifdef FREELIST_COUNT_EN
  logic [5:0] free_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  freelist dut (
    .clock               (clock),
    .reset               (reset),
    .instr0_alloc_req    (instr0_alloc_req),
    .instr1_alloc_req    (instr1_alloc_req),
    .alloc_ready         (alloc_ready),
    .instr0_alloc_preg   (instr0_alloc_preg),
    .instr1_alloc_preg   (instr1_alloc_preg),
    .instr0_release_valid(instr0_release_valid),
    .instr1_release_valid(instr1_release_valid),
    .instr0_release_preg (instr0_release_preg),
    .instr1_release_preg (instr1_release_preg),
    .overflow_err        (overflow_err)
`ifdef FREELIST_COUNT_EN
    ,
    .free_count          (free_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic drive(input logic r0, input logic r1, input logic v0, input logic [5:0] p0,
                       input logic v1, input logic [5:0] p1);
    instr0_alloc_req     = r0;
    instr1_alloc_req     = r1;
    instr0_release_valid = v0;
    instr0_release_preg  = p0;
    instr1_release_valid = v1;
    instr1_release_preg  = p1;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
    n_vec++; if (instr0_alloc_preg !== 6'd32) begin n_err++; $display("FAIL reset_preg0: got %0d want 32", instr0_alloc_preg); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL reset_count: got %0d want 32", free_count); end
`endif
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr1_alloc_preg !== 6'd32) begin n_err++; $display("FAIL reset_preg1: got %0d want 32", instr1_alloc_preg); end
    n_vec++; if (instr0_alloc_preg !== 6'd0) begin n_err++; $display("FAIL reset_unused0: got %0d want 0", instr0_alloc_preg); end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_noreq_ready: got %b want 1", alloc_ready); end
  endtask

  task automatic test_dual_alloc();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd32) begin n_err++; $display("FAIL dual_preg0: got %0d want 32", instr0_alloc_preg); end
    n_vec++; if (instr1_alloc_preg !== 6'd33) begin n_err++; $display("FAIL dual_preg1: got %0d want 33", instr1_alloc_preg); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd34) begin n_err++; $display("FAIL dual_next: got %0d want 34", instr0_alloc_preg); end
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd30) begin n_err++; $display("FAIL dual_count: got %0d want 30", free_count); end
`endif
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_slot1_alloc();
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr1_alloc_preg !== 6'd32) begin n_err++; $display("FAIL slot1_preg1: got %0d want 32", instr1_alloc_preg); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd33) begin n_err++; $display("FAIL slot1_head: got %0d want 33", instr0_alloc_preg); end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_drain();
    logic [5:0] e0, e1;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      e0 = 6'd32 + 6'(2 * k);
      e1 = 6'd33 + 6'(2 * k);
      drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      n_vec++;
      if (instr0_alloc_preg !== e0 || instr1_alloc_preg !== e1 || alloc_ready !== 1'b1) begin
        n_err++;
        $display("FAIL drain_step%0d: got %0d/%0d rdy %b want %0d/%0d rdy 1", k,
                 instr0_alloc_preg, instr1_alloc_preg, alloc_ready, e0, e1);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL empty_ready_r0: got %b want 0", alloc_ready); end
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL empty_ready_r1: got %b want 0", alloc_ready); end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL empty_ready_none: got %b want 1", alloc_ready); end
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd0) begin n_err++; $display("FAIL empty_count: got %0d want 0", free_count); end
`endif
  endtask

  // Continues from the empty list left by test_drain (head = tail = 0).
  task automatic test_release_at_empty();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd5);
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL rel_empty_bypass: got %b want 0", alloc_ready); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd5) begin n_err++; $display("FAIL rel_empty_preg: got %0d want 5", instr0_alloc_preg); end
    n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL rel_empty_ready: got %b want 1", alloc_ready); end
  endtask

  // Starts at count 1 holding {5}.
  task automatic test_simultaneous();
    drive(1'b1, 1'b1, 1'b1, 6'd7, 1'b1, 6'd9);
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL sim_ready: got %b want 0", alloc_ready); end
    tick();
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd3) begin n_err++; $display("FAIL sim_count: got %0d want 3", free_count); end
`endif
    drive(1'b1, 1'b1, 1'b1, 6'd11, 1'b0, 6'd0);
    n_vec++;
    if (instr0_alloc_preg !== 6'd5 || instr1_alloc_preg !== 6'd7 || alloc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sim_order: got %0d/%0d rdy %b want 5/7 rdy 1", instr0_alloc_preg, instr1_alloc_preg, alloc_ready);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++;
    if (instr0_alloc_preg !== 6'd9 || instr1_alloc_preg !== 6'd11 || alloc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sim_both: got %0d/%0d rdy %b want 9/11 rdy 1", instr0_alloc_preg, instr1_alloc_preg, alloc_ready);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL sim_drained: got %b want 0", alloc_ready); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL sim_ovf: got %b want 0", overflow_err); end
  endtask

  // Starts empty; preg 0 must be accepted like any other value.
  task automatic test_release_zero();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++;
    if (alloc_ready !== 1'b1 || instr1_alloc_preg !== 6'd0) begin
      n_err++;
      $display("FAIL rel_zero: got rdy %b preg %0d want rdy 1 preg 0", alloc_ready, instr1_alloc_preg);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
    n_vec++; if (instr0_alloc_preg !== 6'd32) begin n_err++; $display("FAIL ovf_untouched: got %0d want 32", instr0_alloc_preg); end
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL ovf_count: got %0d want 32", free_count); end
`endif
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    repeat (3) tick();
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    apply_reset();
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow_err); end
    // Full list, one allocation frees exactly one slot: slot0 release fits, slot1 is dropped.
    drive(1'b1, 1'b0, 1'b1, 6'd50, 1'b1, 6'd51);
    tick();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_partial: got %b want 1", overflow_err); end
    n_vec++;
    if (instr0_alloc_preg !== 6'd33 || instr1_alloc_preg !== 6'd34 || alloc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_partial_alloc: got %0d/%0d rdy %b want 33/34 rdy 1", instr0_alloc_preg, instr1_alloc_preg, alloc_ready);
    end
`ifdef FREELIST_COUNT_EN
    n_vec++; if (free_count !== 6'd32) begin n_err++; $display("FAIL ovf_partial_count: got %0d want 32", free_count); end
`endif
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 6'd3, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd34) begin n_err++; $display("FAIL mid_pre: got %0d want 34", instr0_alloc_preg); end
    #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (instr0_alloc_preg !== 6'd32 || instr1_alloc_preg !== 6'd33 || alloc_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_async: got %0d/%0d rdy %b want 32/33 rdy 1", instr0_alloc_preg, instr1_alloc_preg, alloc_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    n_vec++; if (instr0_alloc_preg !== 6'd32) begin n_err++; $display("FAIL mid_post: got %0d want 32", instr0_alloc_preg); end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  initial begin
    test_reset();
    test_dual_alloc();
    test_slot1_alloc();
    test_drain();
    test_release_at_empty();
    test_simultaneous();
    test_release_zero();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
